// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared types and default widths for the MIPS trace buffer.
// TRACE_TIMESTAMP_EN adds a cycle timestamp field to the trace entry.
package mips_dbg_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} trace_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int TS_W       = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]       ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: one write port, one registered read port with read enable.
// Storage is not reset; only the read register is.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem[waddr_i] <= wdata_i;

    always_ff @(posedge clk or posedge rst)
        if (rst) rdata_o <= '0;
        else if (re_i) rdata_o <= mem[raddr_i];

endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: circular {PC, instr} capture frozen POST_TRIG entries after a PC match.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle count per entry and expose rd_ts.
module mips_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       trace_valid,
    input  logic [ADDR_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          instr_in,
    input  logic                       trig_en,
    input  logic [ADDR_W-1:0]          trig_pc,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   trig_pos,
    output logic                       rd_valid,
    output logic                       rd_err,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_instr
`ifdef TRACE_TIMESTAMP_EN
    ,output logic [TS_W-1:0]           rd_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PT   = AW'(POST_TRIG);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } entry_t;

    trace_state_t  state_q;
    logic [AW-1:0] wr_ptr_q, post_cnt_q, trig_pos_q, rd_addr;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, done_q, rd_valid_q, rd_err_q, zero_q;
    logic          we, hit, rd_hit, in_range;
    entry_t        wdata, rdata;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) ts_q <= '0;
        else ts_q <= ts_q + 1'b1;
`endif

    always_comb begin
        we       = trace_valid && !abort && !arm && (state_q == ARMED || state_q == POST);
        hit      = state_q == ARMED && trig_en && pc_in == trig_pc;
        count_d  = count_q == FULL ? FULL : count_q + 1'b1;
        rd_hit   = rd_en && state_q == DONE;
        in_range = {1'b0, rd_idx} < count_q;
        // Once the buffer has wrapped, the oldest entry sits at the write pointer.
        rd_addr  = (count_q == FULL ? wr_ptr_q : '0) + rd_idx;
        wdata.pc    = pc_in;
        wdata.instr = instr_in;
`ifdef TRACE_TIMESTAMP_EN
        wdata.ts    = ts_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            trig_pos_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (arm) begin
            state_q    <= ARMED;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            trig_pos_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else if (we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_d;
            if ((hit && POST_TRIG == 0) || (state_q == POST && post_cnt_q == AW'(1))) begin
                state_q    <= DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                trig_pos_q <= AW'(count_d - CW'(POST_TRIG + 1));
            end else if (hit) begin
                state_q    <= POST;
                post_cnt_q <= PT;
            end else if (state_q == POST) begin
                post_cnt_q <= post_cnt_q - 1'b1;
            end
        end
    end

    // zero_q forces the data outputs to zero after an out-of-range read and holds across idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            rd_valid_q <= rd_hit;
            rd_err_q   <= rd_hit && !in_range;
            if (rd_hit) zero_q <= !in_range;
        end
    end

    trace_ram #(.DEPTH(DEPTH), .W($bits(entry_t))) u_ram (
        .clk     (clk),
        .rst     (reset),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (rd_hit && in_range),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign trig_pos = trig_pos_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_pc    = zero_q ? '0 : rdata.pc;
    assign rd_instr = zero_q ? '0 : rdata.instr;
`ifdef TRACE_TIMESTAMP_EN
    assign rd_ts    = zero_q ? '0 : rdata.ts;
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: directed checks of capture, trigger, wrap, read and abort with DEPTH=8, POST_TRIG=2.
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, arm, abort, trace_valid, trig_en, rd_en;
    logic [31:0] pc_in, instr_in, trig_pc;
    logic [2:0]  rd_idx;
    logic        busy, done, rd_valid, rd_err;
    logic [3:0]  count;
    logic [2:0]  trig_pos;
    logic [31:0] rd_pc, rd_instr;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] rd_ts;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .POST_TRIG(2)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trace_valid(trace_valid),
        .pc_in(pc_in), .instr_in(instr_in), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_en(rd_en), .rd_idx(rd_idx), .busy(busy), .done(done), .count(count),
        .trig_pos(trig_pos), .rd_valid(rd_valid), .rd_err(rd_err), .rd_pc(rd_pc),
        .rd_instr(rd_instr)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_ts(rd_ts)
`endif
    );

    function automatic logic [31:0] ins(input logic [31:0] p);
        return p ^ 32'hA5A5_0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic push(input logic [31:0] p);
        trace_valid = 1'b1;
        pc_in = p;
        instr_in = ins(p);
        tick();
        trace_valid = 1'b0;
    endtask

    task automatic rd(input logic [2:0] i);
        rd_en = 1'b1;
        rd_idx = i;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if ({busy, done, count, trig_pos, rd_valid, rd_err} !== '0 || rd_pc !== 0 || rd_instr !== 0) begin
            errors++; $display("FAIL reset_state: got busy=%b done=%b count=%0d rd_pc=%h expected all zero", busy, done, count, rd_pc);
        end
        reset = 1'b0;
        tick();
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 5; i++) push(32'(i * 4));
        checks++; if (count !== 4'd5 || busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_capture: got count=%0d busy=%b expected 5 1", count, busy);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b count=%0d rd_valid=%b expected 0 0 0 0", busy, done, count, rd_valid);
        end
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        trig_en = 1'b1;
        trig_pc = 32'h08;
        do_arm();
        push(32'h00); push(32'h04); push(32'h08);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== 4'd3) begin
            errors++; $display("FAIL post_state: got busy=%b done=%b count=%0d expected 1 0 3", busy, done, count);
        end
        push(32'h0C);
        checks++; if (done !== 1'b0) begin
            errors++; $display("FAIL early_done: got done=%b expected 0", done);
        end
        push(32'h10);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd5 || trig_pos !== 3'd2) begin
            errors++; $display("FAIL basic_done: got done=%b busy=%b count=%0d trig_pos=%0d expected 1 0 5 2", done, busy, count, trig_pos);
        end
        for (int i = 0; i < 5; i++) begin
            rd(3'(i));
            checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_pc !== 32'(i * 4) || rd_instr !== ins(32'(i * 4))) begin
                errors++; $display("FAIL basic_read%0d: got v=%b e=%b pc=%h instr=%h expected 1 0 %h %h", i, rd_valid, rd_err, rd_pc, rd_instr, 32'(i * 4), ins(32'(i * 4)));
            end
        end
        tick();
        checks++; if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_strobe: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_wrap;
        trig_pc = 32'h24;
        do_arm();
        for (int i = 0; i < 12; i++) push(32'(i * 4));
        checks++; if (done !== 1'b1 || count !== 4'd8 || trig_pos !== 3'd5) begin
            errors++; $display("FAIL wrap_done: got done=%b count=%0d trig_pos=%0d expected 1 8 5", done, count, trig_pos);
        end
        rd(3'd0);
        checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'h10) begin
            errors++; $display("FAIL wrap_oldest: got v=%b pc=%h expected 1 10", rd_valid, rd_pc);
        end
        rd(3'd7);
        checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'h2C || rd_instr !== ins(32'h2C)) begin
            errors++; $display("FAIL wrap_newest: got v=%b pc=%h expected 1 2c", rd_valid, rd_pc);
        end
    endtask

    task automatic test_err;
        trig_pc = 32'h08;
        do_arm();
        for (int i = 0; i < 5; i++) push(32'(i * 4));
        rd(3'd6);
        checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_pc !== 0 || rd_instr !== 0) begin
            errors++; $display("FAIL read_err: got v=%b e=%b pc=%h instr=%h expected 1 1 0 0", rd_valid, rd_err, rd_pc, rd_instr);
        end
        rd(3'd2);
        checks++; if (rd_err !== 1'b0 || rd_pc !== 32'h08) begin
            errors++; $display("FAIL read_after_err: got e=%b pc=%h expected 0 8", rd_err, rd_pc);
        end
        trig_en = 1'b0;
        do_arm();
        push(32'h40);
        rd(3'd0);
        checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_pc !== 32'h08) begin
            errors++; $display("FAIL read_armed: got v=%b e=%b pc=%h expected 0 0 8 (held)", rd_valid, rd_err, rd_pc);
        end
    endtask

    task automatic test_abort;
        trig_en = 1'b1;
        trig_pc = 32'h08;
        do_arm();
        push(32'h00); push(32'h04); push(32'h08);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL abort_post: got busy=%b done=%b count=%0d expected 0 0 0", busy, done, count);
        end
        push(32'h0C); push(32'h10);
        checks++; if (count !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_ignores: got count=%0d busy=%b expected 0 0", count, busy);
        end
        arm = 1'b1;
        trace_valid = 1'b1;
        pc_in = 32'h40;
        instr_in = ins(32'h40);
        tick();
        arm = 1'b0;
        trace_valid = 1'b0;
        checks++; if (count !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL arm_drop: got count=%0d busy=%b expected 0 1", count, busy);
        end
        trig_pc = 32'h44;
        push(32'h44); push(32'h48); push(32'h4C);
        checks++; if (done !== 1'b1 || count !== 4'd3 || trig_pos !== 3'd0) begin
            errors++; $display("FAIL arm_drop_done: got done=%b count=%0d trig_pos=%0d expected 1 3 0", done, count, trig_pos);
        end
        rd(3'd0);
        checks++; if (rd_pc !== 32'h44) begin
            errors++; $display("FAIL arm_drop_first: got pc=%h expected 44", rd_pc);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (done !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL abort_done: got done=%b count=%0d expected 0 0", done, count);
        end
    endtask

    task automatic test_no_trig;
        trig_en = 1'b0;
        trig_pc = 32'h08;
        do_arm();
        for (int i = 0; i < 20; i++) push(32'(i * 4));
        checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== 4'd8) begin
            errors++; $display("FAIL no_trig: got busy=%b done=%b count=%0d expected 1 0 8", busy, done, count);
        end
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp;
        logic [31:0] t0;
        trig_en = 1'b1;
        trig_pc = 32'h100;
        do_arm();
        push(32'h100); push(32'h104); push(32'h108);
        rd(3'd0);
        t0 = rd_ts;
        for (int i = 1; i < 3; i++) begin
            rd(3'(i));
            checks++; if (rd_ts !== t0 + 32'(i)) begin
                errors++; $display("FAIL ts_step%0d: got %0d expected %0d", i, rd_ts, t0 + 32'(i));
            end
        end
        rd(3'd5);
        checks++; if (rd_ts !== 0) begin
            errors++; $display("FAIL ts_err_zero: got %0d expected 0", rd_ts);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trace_valid = 1'b0; trig_en = 1'b0;
        rd_en = 1'b0; pc_in = '0; instr_in = '0; trig_pc = '0; rd_idx = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_err();
        test_abort();
        test_no_trig();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Parametrised on-chip trace capture for the MIPS core; a hardware successor to printing PC/instruction every cycle.
- Records {PC, instruction} pairs into a circular buffer while armed.
- Freezes a fixed number of entries after a PC-match trigger, then exposes the window through a registered read port.
- Sits beside mips_core; taps PC and instruction and is read by the bench or a debug interface.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, instruction width
- DEPTH, 16, buffer entries; power of two, >= 2
- POST_TRIG, 4, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  pulse: start a new capture
- abort  in  1  pulse: stop capture and return to IDLE
- trace_valid  in  1  qualifies pc_in/instr_in this cycle (one retired instruction)
- pc_in  in  ADDR_W  PC of the traced instruction
- instr_in  in  DATA_W  traced instruction word
- trig_en  in  1  enables the PC-match trigger
- trig_pc  in  ADDR_W  trigger PC
- rd_en  in  1  read request
- rd_idx  in  $clog2(DEPTH)  read index; 0 = oldest entry
- busy  out  1  state is ARMED or POST
- done  out  1  state is DONE
- count  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
- trig_pos  out  $clog2(DEPTH)  index of the trigger entry, relative to oldest
- rd_valid  out  1  read response strobe
- rd_err  out  1  read index out of range
- rd_pc  out  ADDR_W  read PC
- rd_instr  out  DATA_W  read instruction

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
  - Reset state: IDLE, wr_ptr=0.
  - All outputs reset to 0: busy, done, count, trig_pos, rd_valid, rd_err, rd_pc, rd_instr.
  - Buffer storage is not reset.
- FSM states: IDLE, ARMED, POST, DONE. abort has priority over arm, and arm has priority over every other event.
- IDLE:
  - arm -> ARMED, with wr_ptr=0, count=0, trig_pos=0.
  - trace_valid is ignored.
- ARMED, on each trace_valid:
  - Write the entry at wr_ptr; wr_ptr wraps modulo DEPTH; count saturates at DEPTH (oldest entry overwritten).
  - If trig_en and pc_in==trig_pc, the matching entry is still written. Then:
    - POST_TRIG==0 -> DONE.
    - Otherwise -> POST with post_cnt=POST_TRIG.
- POST:
  - Each trace_valid writes an entry and decrements post_cnt.
  - The write that takes post_cnt to 0 transitions to DONE in the same edge.
  - Further trigger matches are ignored.
- DONE:
  - No writes; buffer frozen.
  - trig_pos = count-1-POST_TRIG, registered on entry to DONE.
- arm in ARMED/POST/DONE restarts: -> ARMED with pointers and counters cleared.
- abort in any state -> IDLE, count=0; done deasserts the next cycle.
- Read port, 1-cycle latency:
  - rd_en in DONE with rd_idx<count: next cycle rd_valid=1, rd_err=0.
    - Data is the entry at (oldest+rd_idx) mod DEPTH.
    - oldest = 0 if count<DEPTH, else wr_ptr.
  - rd_en in DONE with rd_idx>=count: rd_valid=1, rd_err=1, rd_pc=rd_instr=0.
  - rd_en outside DONE: rd_valid=0 next cycle; rd_pc/rd_instr hold their previous values.
  - rd_valid and rd_err are single-cycle strobes.
- Simultaneous events:
  - trace_valid with arm: the sample is dropped; capture starts the next cycle.
  - trace_valid with abort: the sample is dropped.
  - rd_en on the cycle DONE is entered is ignored, because the state is not yet DONE.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is stored with each entry.
  - Extra output rd_ts (32 bits) carries it with the same latency and zeroing rules as rd_pc.
- Undefined: no counter, no rd_ts port, no added storage.

Decomposition:
- Package mips_dbg_pkg:
  - State enum trace_state_t {IDLE, ARMED, POST, DONE}.
  - Default widths: ADDR_W=32, DATA_W=32.
  - Trace entry struct {pc, instr[, ts]}.
- One natural sub-module: trace_ram, a simple dual-port memory with one write port and one registered read port, parametrised by DEPTH and entry width.
- FSM, pointers and read-index translation stay in the top level.

Test Plan (DEPTH=8, POST_TRIG=2):
- Reset mid-capture (ARMED, count=5), assert reset asynchronously -> busy=0, done=0, count=0, rd_valid=0 immediately, before the next clk edge.
- arm; 5 samples PC 0x00,0x04,0x08,0x0C,0x10, trig_pc=0x08 -> DONE after PC 0x10; count=5, trig_pos=2; rd_idx 0..4 return PCs 0x00..0x10 in order, each 1 cycle after rd_en.
- arm; 12 samples PC 0x00..0x2C, trigger at 0x24 -> DONE after 0x2C; count=8, trig_pos=5; rd_idx=0 returns 0x10, rd_idx=7 returns 0x2C.
- DONE with count=5, rd_idx=6 -> rd_valid=1, rd_err=1, rd_pc=0; rd_en while ARMED -> rd_valid stays 0.
- abort during POST -> IDLE next cycle, count=0; later trace_valid writes nothing (count stays 0); arm asserted with trace_valid -> that sample is not recorded.
- trig_en=0, 20 samples -> remains ARMED, count=8, done=0; with TRACE_TIMESTAMP_EN defined, rd_ts increases by one per back-to-back sample.
